// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control unit.
package booth_pkg;

  localparam int BOOTH_DEFAULT_WIDTH = 8;

  // {q0, q_1} pairs that call for an add or subtract of M before the shift.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    TEST   = 4'd3,
    ADD    = 4'd4,
    SUB    = 4'd5,
    SHIFT  = 4'd6,
    OUT_A  = 4'd7,
    OUT_Q  = 4'd8,
    DONE   = 4'd9
  } booth_state_t;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: clear, saturating increment, last-iteration flag.
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_VAL  = CW'(WIDTH);

  logic [CW-1:0] cnt;

  // Saturates at WIDTH so a stray increment can never wrap the count.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_VAL)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control FSM issuing strobes c0..c6, busy and fin.
// Optional abort input enabled by defining BOOTH_CTRL_ABORT_EN.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bgn,
  input  logic q0,
  input  logic q_1,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic fin
);

  booth_state_t state;
  booth_state_t state_next;
  logic         last_iter;
  logic         abort_hit;

`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  booth_iter_cnt #(
    .WIDTH(WIDTH)
  ) u_iter_cnt (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  ((state == LOAD_M) || abort_hit),
    .inc  (state == SHIFT),
    .last (last_iter)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bgn) state_next = LOAD_M;
      LOAD_M:  state_next = LOAD_Q;
      LOAD_Q:  state_next = TEST;
      TEST: begin
        case ({q0, q_1})
          BOOTH_ADD: state_next = ADD;
          BOOTH_SUB: state_next = SUB;
          default:   state_next = SHIFT;
        endcase
      end
      ADD:     state_next = SHIFT;
      SUB:     state_next = SHIFT;
      SHIFT:   state_next = last_iter ? OUT_A : TEST;
      OUT_A:   state_next = OUT_Q;
      OUT_Q:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      c0    <= 1'b0;
      c1    <= 1'b0;
      c2    <= 1'b0;
      c3    <= 1'b0;
      c4    <= 1'b0;
      c5    <= 1'b0;
      c6    <= 1'b0;
      busy  <= 1'b0;
      fin   <= 1'b0;
    end else begin
      state <= state_next;
      c0    <= (state_next == LOAD_M);
      c1    <= (state_next == LOAD_Q);
      c2    <= (state_next == ADD);
      c3    <= (state_next == SUB);
      c4    <= (state_next == SHIFT);
      c5    <= (state_next == OUT_A);
      c6    <= (state_next == OUT_Q);
      busy  <= (state_next != IDLE);
      fin   <= (state_next == DONE);
    end
  end

endmodule
